// File: rtl/sm83_pkg.sv
// Shared SM83 types: interrupt dispatch state encoding, vector constants and helpers.
package sm83_pkg;

    localparam int          IRQ_N          = 5;
    localparam logic [15:0] IRQ_VEC_BASE   = 16'h0040;
    localparam int          IRQ_VEC_STRIDE = 8;

    typedef logic [IRQ_N-1:0] irq_vec_t;

    typedef enum logic [2:0] {
        IRQ_IDLE,
        IRQ_WAIT0,
        IRQ_WAIT1,
        IRQ_PUSH_HI,
        IRQ_PUSH_LO,
        IRQ_JUMP
    } irq_state_t;

    function automatic logic [15:0] irq_vector(logic [15:0] base, int stride, int idx);
        return base + 16'(idx * stride);
    endfunction

endpackage

// File: rtl/irq_dispatch_ctrl_prio_enc.sv
// irq_prio_enc: combinational lowest-set-bit encoder; bit 0 has highest priority.
module irq_prio_enc #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IW'(i);
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/irq_dispatch_ctrl.sv
// SM83 interrupt controller: IME tracking and interrupt dispatch sequencing.
// Optional macro IRQ_EI_DELAY_EN: EI takes effect one instruction boundary late.
import sm83_pkg::*;

module irq_dispatch_ctrl #(
    parameter int          N_IRQ      = IRQ_N,
    parameter logic [15:0] VEC_BASE   = IRQ_VEC_BASE,
    parameter int          VEC_STRIDE = IRQ_VEC_STRIDE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ie,
    input  logic [N_IRQ-1:0] if_req,
    input  logic             insn_boundary,
    input  logic             ei,
    input  logic             di,
    input  logic             reti,
    input  logic [15:0]      r_pc,
    input  logic [15:0]      r_sp,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             wen_pc,
    output logic             wen_sp,
    output logic [15:0]      w_pc,
    output logic [15:0]      w_sp,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             busy,
    output logic             halt_wake,
    output logic             ime
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_t      state_q, state_d;
    logic            ime_q, ime_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     pc_q, pc_d, sp_q, sp_d;
    logic [N_IRQ-1:0] pending;
    logic [IW-1:0]   sel_idx;
    logic            sel_vld;
    logic            start;

    if (N_IRQ < 8) begin : g_ie_tail
        logic unused_ie;
        assign unused_ie = ^ie[7:N_IRQ];
    end

    assign pending   = ie[N_IRQ-1:0] & if_req;
    assign halt_wake = |pending;
    assign ime       = ime_q;

    irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_prio (
        .req_i   (pending),
        .idx_o   (sel_idx),
        .valid_o (sel_vld)
    );

    // Dispatch decision uses the IME from before any same-cycle promotion.
    assign start = (state_q == IRQ_IDLE) && insn_boundary && ime_q && sel_vld;

`ifdef IRQ_EI_DELAY_EN
    logic ei_pend_q, ei_pend_d;
`endif

    always_comb begin
        ime_d = ime_q;
`ifdef IRQ_EI_DELAY_EN
        ei_pend_d = ei_pend_q;
        if ((state_q == IRQ_IDLE) && insn_boundary && ei_pend_q) begin
            ime_d     = 1'b1;
            ei_pend_d = 1'b0;
        end
        if (ei) ei_pend_d = 1'b1;
`else
        if (ei) ime_d = 1'b1;
`endif
        if (reti) ime_d = 1'b1;
        if (di || start) begin
            ime_d = 1'b0;
`ifdef IRQ_EI_DELAY_EN
            ei_pend_d = 1'b0;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        case (state_q)
            IRQ_IDLE: if (start) begin
                state_d = IRQ_WAIT0;
                idx_d   = sel_idx;
                pc_d    = r_pc;
                sp_d    = r_sp;
            end
            IRQ_WAIT0:   state_d = IRQ_WAIT1;
            IRQ_WAIT1:   state_d = IRQ_PUSH_HI;
            IRQ_PUSH_HI: if (mem_ack) state_d = IRQ_PUSH_LO;
            IRQ_PUSH_LO: if (mem_ack) state_d = IRQ_JUMP;
            IRQ_JUMP:    state_d = IRQ_IDLE;
            default:     state_d = IRQ_IDLE;
        endcase
    end

    // Outputs decode from state and latched context only, never from mem_ack.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wen_pc    = 1'b0;
        wen_sp    = 1'b0;
        w_pc      = '0;
        w_sp      = '0;
        irq_ack   = '0;
        busy      = (state_q != IRQ_IDLE);
        case (state_q)
            IRQ_PUSH_HI: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q - 16'd1;
                mem_wdata = pc_q[15:8];
            end
            IRQ_PUSH_LO: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q - 16'd2;
                mem_wdata = pc_q[7:0];
            end
            IRQ_JUMP: begin
                wen_pc  = 1'b1;
                w_pc    = irq_vector(VEC_BASE, VEC_STRIDE, int'(idx_q));
                wen_sp  = 1'b1;
                w_sp    = sp_q - 16'd2;
                irq_ack = {{(N_IRQ-1){1'b0}}, 1'b1} << idx_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IRQ_IDLE;
            ime_q   <= 1'b0;
            idx_q   <= '0;
            pc_q    <= '0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            ime_q   <= ime_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
        end
    end

`ifdef IRQ_EI_DELAY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ei_pend_q <= 1'b0;
        else        ei_pend_q <= ei_pend_d;
    end
`endif

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Self-checking bench for irq_dispatch_ctrl: vector table, directed corners, random vs model.
module tb_irq_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ie;
    logic [4:0]  if_req;
    logic        insn_boundary, ei, di, reti;
    logic [15:0] r_pc, r_sp;
    logic        mem_ack;
    logic        mem_req, mem_we, wen_pc, wen_sp, busy, halt_wake, ime;
    logic [15:0] mem_addr, w_pc, w_sp;
    logic [7:0]  mem_wdata;
    logic [4:0]  irq_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_dispatch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ie(ie), .if_req(if_req),
        .insn_boundary(insn_boundary), .ei(ei), .di(di), .reti(reti),
        .r_pc(r_pc), .r_sp(r_sp), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .wen_pc(wen_pc), .wen_sp(wen_sp), .w_pc(w_pc), .w_sp(w_sp),
        .irq_ack(irq_ack), .busy(busy), .halt_wake(halt_wake), .ime(ime)
    );

    typedef struct {
        logic [15:0] ha;  logic [7:0] hd;
        logic [15:0] la;  logic [7:0] ld;
        logic [15:0] wpc; logic [15:0] wsp;
        logic [4:0]  ack;
        int len; int nwr; int nack; int npc; int bad;
    } res_t;

    typedef struct {
        logic [7:0] ie; logic [4:0] ifr; logic [15:0] pc, sp;
        int st_hi, st_lo;
        logic [15:0] e_ha; logic [7:0] e_hd; logic [15:0] e_la; logic [7:0] e_ld;
        logic [15:0] e_pc, e_sp; logic [4:0] e_ack; int e_len;
    } vec_t;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    // Reference: pushes PC big-end first below SP, jumps to vector of lowest pending source.
    function automatic res_t model(logic [7:0] ie_v, logic [4:0] if_v, logic [15:0] pc_v,
                                   logic [15:0] sp_v, int st_hi, int st_lo);
        res_t m;
        int idx = 0;
        logic [4:0] p = ie_v[4:0] & if_v;
        for (int i = 4; i >= 0; i--) if (p[i]) idx = i;
        m.ha = sp_v - 16'd1;  m.hd = pc_v[15:8];
        m.la = sp_v - 16'd2;  m.ld = pc_v[7:0];
        m.wpc = 16'h0040 + 16'(idx * 8);
        m.wsp = sp_v - 16'd2;
        m.ack = 5'(1 << idx);
        m.len = 5 + st_hi + st_lo;
        m.nwr = 2; m.nack = 1; m.npc = 1; m.bad = 0;
        return m;
    endfunction

    task automatic cmp(string t, res_t r, res_t e);
        chk({t, " push_hi_addr"}, 32'(r.ha), 32'(e.ha));
        chk({t, " push_hi_data"}, 32'(r.hd), 32'(e.hd));
        chk({t, " push_lo_addr"}, 32'(r.la), 32'(e.la));
        chk({t, " push_lo_data"}, 32'(r.ld), 32'(e.ld));
        chk({t, " w_pc"},         32'(r.wpc), 32'(e.wpc));
        chk({t, " w_sp"},         32'(r.wsp), 32'(e.wsp));
        chk({t, " irq_ack"},      32'(r.ack), 32'(e.ack));
        chk({t, " busy_len"},     32'(r.len), 32'(e.len));
        chk({t, " n_writes"},     32'(r.nwr), 32'(e.nwr));
        chk({t, " n_ack_pulses"}, 32'(r.nack), 32'(e.nack));
        chk({t, " n_wen_pc"},     32'(r.npc), 32'(e.npc));
        chk({t, " bus_unstable"}, 32'(r.bad), 32'(e.bad));
        chk({t, " ime_after"},    32'(ime), 32'd0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_reti();
        reti = 1'b1; step(); reti = 1'b0;
    endtask

    // Strobe a boundary, then service the bus with the given stall counts.
    task automatic run_disp(input logic [7:0] ie_v, input logic [4:0] if_v, input logic [4:0] if_mid,
                            input logic [15:0] pc_v, input logic [15:0] sp_v,
                            input int st_hi, input int st_lo, output res_t r);
        int stall = 0;
        logic pv = 1'b0;
        logic [15:0] pa = '0;
        logic [7:0]  pd = '0;
        r = '{default: 0};
        ie = ie_v; if_req = if_v; r_pc = pc_v; r_sp = sp_v;
        insn_boundary = 1'b1; mem_ack = 1'b0;
        step();
        insn_boundary = 1'b0; if_req = if_mid; r_pc = ~pc_v; r_sp = ~sp_v;
        for (int c = 0; c < 60 && busy; c++) begin
            r.len++;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!mem_we) r.bad++;
                if (pv && (mem_addr !== pa || mem_wdata !== pd)) r.bad++;
                pv = 1'b1; pa = mem_addr; pd = mem_wdata;
                if (stall < ((r.nwr == 0) ? st_hi : st_lo)) stall++;
                else begin
                    mem_ack = 1'b1; stall = 0; pv = 1'b0;
                    if (r.nwr == 0) begin r.ha = mem_addr; r.hd = mem_wdata; end
                    else begin r.la = mem_addr; r.ld = mem_wdata; end
                    r.nwr++;
                end
            end
            if (irq_ack != 5'd0) begin r.nack++; r.ack = irq_ack; end
            if (wen_pc) begin r.npc++; r.wpc = w_pc; end
            if (wen_sp) r.wsp = w_sp;
            step();
        end
        mem_ack = 1'b0;
    endtask

    task automatic drain();
        mem_ack = 1'b1;
        for (int c = 0; c < 20 && busy; c++) step();
        mem_ack = 1'b0;
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    vec_t vecs[4];
    res_t r, e;

    initial begin
        vecs[0] = '{8'h1F, 5'b10100, 16'h1234, 16'hFFFE, 0, 0,
                    16'hFFFD, 8'h12, 16'hFFFC, 8'h34, 16'h0050, 16'hFFFC, 5'b00100, 5};
        vecs[1] = '{8'h1F, 5'b10100, 16'h1234, 16'hFFFE, 3, 0,
                    16'hFFFD, 8'h12, 16'hFFFC, 8'h34, 16'h0050, 16'hFFFC, 5'b00100, 8};
        vecs[2] = '{8'h1F, 5'b00001, 16'hABCD, 16'h0001, 0, 0,
                    16'h0000, 8'hAB, 16'hFFFF, 8'hCD, 16'h0040, 16'hFFFF, 5'b00001, 5};
        vecs[3] = '{8'h1F, 5'b10000, 16'h0000, 16'h0000, 1, 2,
                    16'hFFFF, 8'h00, 16'hFFFE, 8'h00, 16'h0060, 16'hFFFE, 5'b10000, 8};

        rst_n = 1'b0; ie = '0; if_req = '0; insn_boundary = 0; ei = 0; di = 0; reti = 0;
        r_pc = '0; r_sp = '0; mem_ack = 0;
        #17;
        chk("rst ime", 32'(ime), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst strobes", 32'({mem_req, mem_we, wen_pc, wen_sp}), 0);
        chk("rst irq_ack", 32'(irq_ack), 0);
        chk("rst buses", 32'(mem_addr | w_pc | w_sp | 16'(mem_wdata)), 0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            pulse_reti();
            run_disp(vecs[i].ie, vecs[i].ifr, vecs[i].ifr, vecs[i].pc, vecs[i].sp,
                     vecs[i].st_hi, vecs[i].st_lo, r);
            e = '{vecs[i].e_ha, vecs[i].e_hd, vecs[i].e_la, vecs[i].e_ld, vecs[i].e_pc,
                  vecs[i].e_sp, vecs[i].e_ack, vecs[i].e_len, 2, 1, 1, 0};
            cmp($sformatf("vec%0d", i), r, e);
        end

        // EI latency
        ie = 8'h1F; if_req = 5'b00010; r_pc = 16'h0100; r_sp = 16'hC000;
        ei = 1'b1; step(); ei = 1'b0;
`ifdef IRQ_EI_DELAY_EN
        chk("ei pend not ime", 32'(ime), 0);
        insn_boundary = 1'b1; step(); insn_boundary = 1'b0;
        chk("ei boundary no dispatch", 32'(busy), 0);
        chk("ei promoted", 32'(ime), 1);
        run_disp(8'h1F, 5'b00010, 5'b00010, 16'h0100, 16'hC000, 0, 0, r);
        cmp("ei_next", r, model(8'h1F, 5'b00010, 16'h0100, 16'hC000, 0, 0));
`else
        chk("ei ime set", 32'(ime), 1);
        insn_boundary = 1'b1; step(); insn_boundary = 1'b0;
        chk("ei immediate dispatch", 32'(busy), 1);
        drain();
`endif
        ei = 1'b1; di = 1'b1; step(); ei = 1'b0; di = 1'b0;
        chk("ei+di ime", 32'(ime), 0);
        if_req = 5'b0; insn_boundary = 1'b1; step(); insn_boundary = 1'b0;
        chk("ei+di after boundary", 32'(ime), 0);

        // halt wake without IME, then RETI re-enables
        ie = 8'h04; if_req = 5'b01000; #1;
        chk("halt_wake masked", 32'(halt_wake), 0);
        if_req = 5'b00100; #1;
        chk("halt_wake", 32'(halt_wake), 1);
        step();
        insn_boundary = 1'b1; step(); insn_boundary = 1'b0;
        chk("ime0 no dispatch", 32'(busy), 0);
        pulse_reti();
        chk("reti ime", 32'(ime), 1);
        run_disp(8'h04, 5'b00100, 5'b00100, 16'h2000, 16'hD000, 0, 0, r);
        cmp("reti", r, model(8'h04, 5'b00100, 16'h2000, 16'hD000, 0, 0));

        // reset during PUSH_LO
        pulse_reti();
        ie = 8'h1F; if_req = 5'b00001; r_pc = 16'h5555; r_sp = 16'h8000;
        insn_boundary = 1'b1; step(); insn_boundary = 1'b0;
        for (int c = 0; c < 10 && !(mem_req && mem_addr == 16'h7FFE); c++) begin
            mem_ack = mem_req; step();
        end
        mem_ack = 1'b0;
        chk("reached push_lo", 32'(mem_addr), 32'h7FFE);
        rst_n = 1'b0; #1;
        chk("mid rst busy", 32'(busy), 0);
        chk("mid rst strobes", 32'({mem_req, mem_we, wen_pc, wen_sp}), 0);
        chk("mid rst buses", 32'(mem_addr | w_pc | w_sp | 16'(mem_wdata) | 16'(irq_ack)), 0);
        chk("mid rst ime", 32'(ime), 0);
        #2 rst_n = 1'b1; mem_ack = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin step(); if (wen_pc) seen++; end
            chk("no wen_pc after reset", 32'(seen), 0);
        end
        mem_ack = 1'b0;

        // random dispatches, IF may change mid-dispatch
        for (int n = 0; n < 40; n++) begin
            logic [4:0] ifv, ifm;
            logic [7:0] iev;
            logic [15:0] pc, sp;
            int k, sh, sl;
            k   = $urandom_range(0, 4);
            ifv = 5'($urandom) | 5'(1 << k);
            iev = 8'($urandom) | 8'(1 << k);
            ifm = 5'($urandom);
            pc  = 16'($urandom);
            case ($urandom_range(0, 3))
                0: sp = 16'h0000;
                1: sp = 16'h0001;
                default: sp = 16'($urandom);
            endcase
            sh = $urandom_range(0, 3);
            sl = $urandom_range(0, 3);
            pulse_reti();
            run_disp(iev, ifv, ifm, pc, sp, sh, sl, r);
            cmp($sformatf("rnd%0d", n), r, model(iev, ifv, pc, sp, sh, sl));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_dispatch_ctrl.md
# irq_dispatch_ctrl

Interrupt controller for the SM83 core. Tracks the interrupt master enable (IME), with EI/DI/RETI handling, and prioritises pending requests against IE. At an instruction boundary it sequences the interrupt dispatch: two internal wait cycles, a two-byte push of PC through the memory port, then SP/PC write-back to the register file. It sits between the IO interrupt-flag logic, the memory bus arbiter and the register-file write ports, and stalls the core via `busy` while dispatching.

## Interface
- `N_IRQ`, 5, number of interrupt sources; bit 0 has the highest priority.
- `VEC_BASE`, 16'h0040, vector address of source 0.
- `VEC_STRIDE`, 8, vector spacing in bytes; vector = VEC_BASE + idx*VEC_STRIDE.
- `clk` in 1: core clock. All state is updated on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ie` in 8: IE register value; only bits [N_IRQ-1:0] are used.
- `if_req` in N_IRQ: interrupt-flag bits from IO.
- `insn_boundary` in 1: one-cycle strobe at each instruction completion, before the next fetch.
- `ei`, `di`, `reti` in 1: one-cycle strobes from the decoder.
- `r_pc`, `r_sp` in 16: current PC and SP.
- `mem_ack` in 1: the arbiter accepted the current write.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_wdata` out 8: memory write request.
- `wen_pc`, `wen_sp` out 1; `w_pc`, `w_sp` out 16: register-file write ports.
- `irq_ack` out N_IRQ: one-hot one-cycle pulse that clears the serviced IF bit.
- `busy` out 1: dispatch in progress; the core must not fetch.
- `halt_wake` out 1: combinational, `|(ie & if_req)`, independent of IME.
- `ime` out 1: current IME.

## Operation
- `pending = ie[N_IRQ-1:0] & if_req`. The selected source is the lowest set bit.
- IME control:
  - `di` clears IME and any EI pending.
  - `ei` sets EI pending (see Configuration).
  - `reti` sets IME immediately.
  - If `di` and `ei` occur in the same cycle, `di` wins.
- States: IDLE, WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP.
- IDLE → WAIT0 when `insn_boundary && ime && pending != 0`. On entry:
  - latch `idx`, PC and SP;
  - clear IME and EI pending.
- WAIT0 → WAIT1 → PUSH_HI, one cycle each, unconditionally.
- PUSH_HI:
  - drive `mem_req=1`, `mem_we=1`, `mem_addr=SP-1`, `mem_wdata=PC[15:8]`;
  - hold these values until `mem_ack`, then go to PUSH_LO.
- PUSH_LO:
  - drive `mem_addr=SP-2`, `mem_wdata=PC[7:0]`;
  - hold until `mem_ack`, then go to JUMP.
- JUMP (one cycle):
  - `wen_pc=1`, `w_pc=vector(idx)`;
  - `wen_sp=1`, `w_sp=SP-2`;
  - `irq_ack` has bit `idx` set;
  - then go to IDLE.
- SP arithmetic is modulo 2^16: latched SP 16'h0000 gives 16'hFFFF / 16'hFFFE; 16'h0001 gives 16'h0000 / 16'hFFFF.
- The vector uses the latched `idx`. If the IF bit drops mid-dispatch, the dispatch still completes to the latched vector. If a higher-priority source asserts mid-dispatch, it is not preempted.
- `ei`, `di` and `reti` received while `busy` are applied normally. IME therefore equals its pre-dispatch cleared value unless a strobe changes it.
- `insn_boundary` is ignored outside IDLE.

## Timing
- Reset values:
  - IME=0, EI pending=0, state IDLE;
  - `mem_req`, `mem_we`, `wen_pc`, `wen_sp`, `busy` = 0;
  - `irq_ack` = 0;
  - `mem_addr`, `mem_wdata`, `w_pc`, `w_sp` = 0.
- Reset asserted mid-dispatch aborts immediately to the reset values. No partial register-file write occurs after reset.
- `busy` is high from the cycle after the triggering `insn_boundary` through the JUMP cycle inclusive.
- Minimum dispatch length with `mem_ack` held high is 5 cycles: WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP.
- Each push adds one cycle per cycle of `mem_ack` low.
- All outputs except `halt_wake` are registered or decoded from state only. They must not depend combinationally on `mem_ack`.

## Configuration
- `IRQ_EI_DELAY_EN` defined:
  - EI pending becomes IME on the next `insn_boundary` after the one that ends EI;
  - the dispatch check on that boundary uses the old IME, so the instruction following EI always executes.
- Undefined: `ei` sets IME directly in the cycle after the strobe; EI pending is not implemented.

## Structure
- `sm83_pkg` gains:
  - the `irq_state_t` enum;
  - `IRQ_VEC_BASE` and `IRQ_VEC_STRIDE` constants;
  - an `irq_vec_t` typedef (N_IRQ-bit).
- Sub-module `irq_prio_enc`: combinational lowest-set-bit encoder producing `idx` and `valid`.

## Test plan
- IME=1, IE=8'h1F, IF=5'b10100, PC=16'h1234, SP=16'hFFFE, strobe boundary, `mem_ack`=1 → writes [FFFD]=12 and [FFFC]=34; `w_pc`=16'h0050, `w_sp`=16'hFFFC; `irq_ack`=5'b00100; `busy` high exactly 5 cycles.
- Same stimulus with `mem_ack` low for 3 cycles in PUSH_HI → `mem_addr`/`mem_wdata` stable throughout; `busy` high for 8 cycles.
- SP=16'h0001, IF=5'b00001 → push addresses 0000 then FFFF; `w_sp`=16'hFFFF; `w_pc`=16'h0040.
- `ei`, then boundary with pending → no dispatch when `IRQ_EI_DELAY_EN` is defined, dispatch on the next boundary; immediate dispatch when undefined. `ei` and `di` in the same cycle → IME stays 0.
- IME=0, IE=8'h04, IF=5'b00100 → `halt_wake`=1, no dispatch. Then `reti` → IME=1, dispatch on the next boundary.
- `rst_n` low during PUSH_LO → all outputs reset within the same cycle; no `wen_pc` pulse follows.
